// File: rtl/rc4_phase_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared types and constants for the RC4 decrypt phase sequencer:
//   - state_t   : sequencer FSM states
//   - PH_*      : phase indices used for ph_* bit/slice selection and grant
//   - DEF_*     : default widths for S RAM address/data, key and phase count
//   - phase_of  : maps a sequencer state to the phase that owns the S RAM
// -----------------------------------------------------------------------------
package rc4_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_KEY_W  = 24;
  localparam int DEF_NPH    = 3;

  localparam logic [1:0] PH_INIT = 2'd0;
  localparam logic [1:0] PH_KSA  = 2'd1;
  localparam logic [1:0] PH_PRGA = 2'd2;
  localparam logic [1:0] PH_NONE = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    INIT_GO,
    INIT_WAIT,
    KSA_GO,
    KSA_WAIT,
    PRGA_GO,
    PRGA_WAIT,
    FINISH
  } state_t;

  // Owner of the S RAM port while the sequencer sits in state s.
  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      INIT_GO, INIT_WAIT: phase_of = PH_INIT;
      KSA_GO,  KSA_WAIT:  phase_of = PH_KSA;
      PRGA_GO, PRGA_WAIT: phase_of = PH_PRGA;
      default:            phase_of = PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rc4_phase_sequencer_if.sv
// -----------------------------------------------------------------------------
// rc4_phase_sequencer_if
// Bus between the sequencer and the three RC4 phase blocks, including the
// resulting single S RAM port.
//   ph_start : sequencer -> phases, one-cycle start pulse per phase
//   ph_done  : phases -> sequencer, one-cycle done pulse per phase
//   ph_addr  : phases -> sequencer, packed per-phase S RAM address
//   ph_data  : phases -> sequencer, packed per-phase S RAM write data
//   ph_wren  : phases -> sequencer, per-phase S RAM write enable
//   s_addr/s_data/s_wren : sequencer -> S RAM, muxed port
// Modports: master = sequencer side, slave = phase/RAM side.
// -----------------------------------------------------------------------------
interface rc4_phase_sequencer_if #(
  parameter int NPH    = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic [NPH-1:0]        ph_start;
  logic [NPH-1:0]        ph_done;
  logic [NPH*ADDR_W-1:0] ph_addr;
  logic [NPH*DATA_W-1:0] ph_data;
  logic [NPH-1:0]        ph_wren;
  logic [ADDR_W-1:0]     s_addr;
  logic [DATA_W-1:0]     s_data;
  logic                  s_wren;

  modport master (
    output ph_start,
    input  ph_done,
    input  ph_addr,
    input  ph_data,
    input  ph_wren,
    output s_addr,
    output s_data,
    output s_wren
  );

  modport slave (
    input  ph_start,
    output ph_done,
    output ph_addr,
    output ph_data,
    output ph_wren,
    input  s_addr,
    input  s_data,
    input  s_wren
  );

endinterface

// File: rtl/rc4_phase_sequencer_sram_mux.sv
// -----------------------------------------------------------------------------
// rc4_sram_mux
// Purely combinational NPH-way mux onto the single-port S RAM. The slice
// selected by grant drives the RAM; any grant without a matching phase
// (PH_NONE) parks the port at address 0, data 0, write disabled, so a
// non-granted phase can never write.
// Ports:
//   grant   in  2             owning phase index
//   ph_addr in  NPH*ADDR_W    packed per-phase addresses
//   ph_data in  NPH*DATA_W    packed per-phase write data
//   ph_wren in  NPH           per-phase write enables
//   s_addr  out ADDR_W        RAM address
//   s_data  out DATA_W        RAM write data
//   s_wren  out 1             RAM write enable
// -----------------------------------------------------------------------------
module rc4_sram_mux
  import rc4_pkg::*;
#(
  parameter int NPH    = DEF_NPH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]            grant,
  input  logic [NPH*ADDR_W-1:0] ph_addr,
  input  logic [NPH*DATA_W-1:0] ph_data,
  input  logic [NPH-1:0]        ph_wren,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_data,
  output logic                  s_wren
);

  logic [ADDR_W-1:0] addr_arr [NPH];
  logic [DATA_W-1:0] data_arr [NPH];

  generate
    for (genvar gi = 0; gi < NPH; gi++) begin : g_unpack
      assign addr_arr[gi] = ph_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = ph_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    s_addr = '0;
    s_data = '0;
    s_wren = 1'b0;
    for (int p = 0; p < NPH; p++) begin
      if (int'(grant) == p) begin
        s_addr = addr_arr[p];
        s_data = data_arr[p];
        s_wren = ph_wren[p];
      end
    end
  end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// -----------------------------------------------------------------------------
// rc4_phase_sequencer
// Top-level controller of the RC4 decrypt datapath. Runs S-array init, key
// schedule and PRGA in that order, handing the single S RAM port to whichever
// phase is active.
// Optional build macro: RC4_KEY_SEARCH_EN -- after each PRGA pass the
// msg_ok verdict either ends the run (key_found) or steps key_out and reruns
// all three phases, stopping with key_fail once the all-ones key has failed.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle request for a decrypt run (ignored unless IDLE)
//   key_in     in   key captured when start is accepted
//   msg_ok     in   (search build) PRGA verdict, valid with ph_done[PH_PRGA]
//   key_found  out  (search build) run ended on an accepted message
//   key_fail   out  (search build) run ended with every key rejected
//   key_out    out  key currently applied by the phases
//   grant      out  active phase index, 3 = none
//   busy       out  run in progress
//   done       out  level, set when a run finishes, cleared by next start
//   bus        master side of rc4_phase_sequencer_if (phase handshakes + S RAM)
// -----------------------------------------------------------------------------
module rc4_phase_sequencer
  import rc4_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEY_W  = DEF_KEY_W,
  parameter int NPH    = DEF_NPH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [KEY_W-1:0]     key_in,
`ifdef RC4_KEY_SEARCH_EN
  input  logic                 msg_ok,
  output logic                 key_found,
  output logic                 key_fail,
`endif
  output logic [KEY_W-1:0]     key_out,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic                 done,
  rc4_phase_sequencer_if.master bus
);

  state_t           state_reg, state_next;
  logic [KEY_W-1:0] key_reg, key_next;
  logic [1:0]       grant_reg, grant_next;
  logic [NPH-1:0]   ph_start_reg, ph_start_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
`ifdef RC4_KEY_SEARCH_EN
  logic             found_reg, found_next;
  logic             fail_reg, fail_next;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      key_reg      <= '0;
      grant_reg    <= PH_NONE;
      ph_start_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef RC4_KEY_SEARCH_EN
      found_reg    <= 1'b0;
      fail_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      key_reg      <= key_next;
      grant_reg    <= grant_next;
      ph_start_reg <= ph_start_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
`ifdef RC4_KEY_SEARCH_EN
      found_reg    <= found_next;
      fail_reg     <= fail_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    done_next  = done_reg;
`ifdef RC4_KEY_SEARCH_EN
    found_next = found_reg;
    fail_next  = fail_reg;
`endif

    // Only the granted phase's done bit is looked at, and never in a GO
    // state, so stray or early pulses cannot advance the sequence.
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = INIT_GO;
          key_next   = key_in;
          done_next  = 1'b0;
`ifdef RC4_KEY_SEARCH_EN
          found_next = 1'b0;
          fail_next  = 1'b0;
`endif
        end
      end
      INIT_GO:   state_next = INIT_WAIT;
      INIT_WAIT: if (bus.ph_done[PH_INIT]) state_next = KSA_GO;
      KSA_GO:    state_next = KSA_WAIT;
      KSA_WAIT:  if (bus.ph_done[PH_KSA]) state_next = PRGA_GO;
      PRGA_GO:   state_next = PRGA_WAIT;
      PRGA_WAIT: begin
        if (bus.ph_done[PH_PRGA]) begin
`ifdef RC4_KEY_SEARCH_EN
          if (msg_ok) begin
            state_next = FINISH;
            found_next = 1'b1;
          end else if (key_reg != '1) begin
            // Next candidate key: restart at init without visiting IDLE.
            key_next   = key_reg + 1'b1;
            state_next = INIT_GO;
          end else begin
            state_next = FINISH;
            fail_next  = 1'b1;
          end
`else
          state_next = FINISH;
`endif
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are registered from the next state so grant is already valid
    // in the GO cycle, together with the phase's start pulse.
    grant_next    = phase_of(state_next);
    ph_start_next = '0;
    case (state_next)
      INIT_GO: ph_start_next[PH_INIT] = 1'b1;
      KSA_GO:  ph_start_next[PH_KSA]  = 1'b1;
      PRGA_GO: ph_start_next[PH_PRGA] = 1'b1;
      default: ph_start_next = '0;
    endcase
    busy_next = (state_next != IDLE) && (state_next != FINISH);
    if (state_next == FINISH) done_next = 1'b1;
  end

  // The mux is driven from the registered grant, which reset forces to
  // PH_NONE asynchronously -- that is what drops s_wren at once on reset.
  rc4_sram_mux #(
    .NPH    (NPH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_sram_mux (
    .grant   (grant_reg),
    .ph_addr (bus.ph_addr),
    .ph_data (bus.ph_data),
    .ph_wren (bus.ph_wren),
    .s_addr  (bus.s_addr),
    .s_data  (bus.s_data),
    .s_wren  (bus.s_wren)
  );

  assign bus.ph_start = ph_start_reg;
  assign key_out      = key_reg;
  assign grant        = grant_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
`ifdef RC4_KEY_SEARCH_EN
  assign key_found    = found_reg;
  assign key_fail     = fail_reg;
`endif

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rc4_phase_sequencer
// Directed bench for rc4_phase_sequencer. Inputs are driven and outputs are
// sampled on the falling clock edge. The phase blocks are played by the
// bench: a phase samples its ph_start on a rising edge, works for T cycles,
// then raises ph_done for one cycle. Search-mode tests are compiled in when
// RC4_KEY_SEARCH_EN is defined.
// -----------------------------------------------------------------------------
module tb_rc4_phase_sequencer;
  import rc4_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int KEY_W  = 24;
  localparam int NPH    = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] key_out;
  logic [1:0]       grant;
  logic             busy;
  logic             done;
`ifdef RC4_KEY_SEARCH_EN
  logic             msg_ok;
  logic             key_found;
  logic             key_fail;
  int               gaps;
`endif

  int total = 0;
  int bad   = 0;

  rc4_phase_sequencer_if #(.NPH(NPH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rc4_phase_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .KEY_W  (KEY_W),
    .NPH    (NPH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .key_in    (key_in),
`ifdef RC4_KEY_SEARCH_EN
    .msg_ok    (msg_ok),
    .key_found (key_found),
    .key_fail  (key_fail),
`endif
    .key_out   (key_out),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

`ifdef RC4_KEY_SEARCH_EN
  // One full pass with every phase finishing in its first WAIT cycle.
  // Entered mid INIT_GO; leaves mid the following INIT_GO or FINISH.
  task automatic run_pass(input logic ok);
    for (int p = 0; p < NPH; p++) begin
      if (busy !== 1'b1) gaps++;
      @(negedge clk);
      if (busy !== 1'b1) gaps++;
      bus.ph_done = 3'(1 << p);
      if (p == 2) msg_ok = ok;
      @(negedge clk);
      bus.ph_done = '0;
      msg_ok      = 1'b0;
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    key_in      = '0;
    bus.ph_done = '0;
    bus.ph_addr = '0;
    bus.ph_data = '0;
    bus.ph_wren = '0;
`ifdef RC4_KEY_SEARCH_EN
    msg_ok      = 1'b0;
    gaps        = 0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_grant",    32'(grant),        32'd3);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_done",     32'(done),         32'd0);
    check("rst_key",      32'(key_out),      32'd0);
    check("rst_ph_start", 32'(bus.ph_start), 32'd0);
    check("rst_s_wren",   32'(bus.s_wren),   32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset asserted in INIT_WAIT while phase 0 is writing
    start = 1'b1; key_in = 24'h000055;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    bus.ph_wren = 3'b001; bus.ph_addr = 24'h0000A5;
    #1;
    check("mid_s_wren_on", 32'(bus.s_wren), 32'd1);
    check("mid_s_addr",    32'(bus.s_addr), 32'hA5);
    reset_n = 1'b0;
    #1;
    check("mid_rst_s_wren", 32'(bus.s_wren), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_grant",    32'(grant),        32'd3);
    check("mid_rst_busy",     32'(busy),         32'd0);
    check("mid_rst_ph_start", 32'(bus.ph_start), 32'd0);
    check("mid_rst_key",      32'(key_out),      32'd0);
    @(negedge clk);
    reset_n = 1'b1; bus.ph_wren = '0; bus.ph_addr = '0;
    @(negedge clk);

    // Full pass: phases take 256, 768 and 32 cycles; start is cycle 0
    start = 1'b1; key_in = 24'h000249;
    @(negedge clk);                                   // cycle 1: INIT_GO
    start = 1'b0; key_in = 24'hABCDEF;
    check("go0_ph_start", 32'(bus.ph_start), 32'b001);
    check("go0_grant",    32'(grant),        32'd0);
    check("go0_busy",     32'(busy),         32'd1);
    check("go0_key",      32'(key_out),      32'h000249);
    check("go0_done",     32'(done),         32'd0);
    bus.ph_done = 3'b001;                             // early done in INIT_GO
    @(negedge clk);                                   // cycle 2: INIT_WAIT
    bus.ph_done = '0;
    check("spur_go_ph_start", 32'(bus.ph_start), 32'd0);
    check("spur_go_grant",    32'(grant),        32'd0);
    bus.ph_done = 3'b100;                             // non-granted done
    start = 1'b1; key_in = 24'h123456;                // start while busy
    @(negedge clk);                                   // cycle 3
    bus.ph_done = '0; start = 1'b0;
    check("spur_wait_ph_start", 32'(bus.ph_start), 32'd0);
    check("spur_wait_grant",    32'(grant),        32'd0);
    check("busy_start_key",     32'(key_out),      32'h000249);
    check("busy_start_busy",    32'(busy),         32'd1);
    repeat (255) @(negedge clk);                      // cycle 258
    bus.ph_done = 3'b001;
    @(negedge clk);                                   // cycle 259: KSA_GO
    bus.ph_done = '0;
    check("go1_ph_start", 32'(bus.ph_start), 32'b010);
    check("go1_grant",    32'(grant),        32'd1);
    @(negedge clk);                                   // cycle 260: KSA_WAIT
    bus.ph_addr = {8'h33, 8'h22, 8'h11};
    bus.ph_data = {8'hC3, 8'hB2, 8'hA1};
    bus.ph_wren = 3'b101;
    #1;
    check("mux_s_addr",     32'(bus.s_addr),   32'h22);
    check("mux_s_data",     32'(bus.s_data),   32'hB2);
    check("mux_s_wren_off", 32'(bus.s_wren),   32'd0);
    check("wait1_ph_start", 32'(bus.ph_start), 32'd0);
    bus.ph_wren = 3'b111;
    #1;
    check("mux_s_wren_on", 32'(bus.s_wren), 32'd1);
    bus.ph_wren = '0; bus.ph_addr = '0; bus.ph_data = '0;
    repeat (768) @(negedge clk);                      // cycle 1028
    bus.ph_done = 3'b010;
    @(negedge clk);                                   // cycle 1029: PRGA_GO
    bus.ph_done = '0;
    check("go2_ph_start", 32'(bus.ph_start), 32'b100);
    check("go2_grant",    32'(grant),        32'd2);
    check("go2_busy",     32'(busy),         32'd1);
    repeat (33) @(negedge clk);                       // cycle 1062
    check("pre_done", 32'(done), 32'd0);
    bus.ph_done = 3'b100;
    @(negedge clk);                                   // cycle 1063: FINISH
    bus.ph_done = '0;
    check("fin_done",  32'(done),    32'd1);
    check("fin_busy",  32'(busy),    32'd0);
    check("fin_grant", 32'(grant),   32'd3);
    check("fin_key",   32'(key_out), 32'h000249);
    start = 1'b1; key_in = 24'h777777;                // start during FINISH
    @(negedge clk);                                   // IDLE
    start = 1'b0;
    check("fin_start_busy",     32'(busy),         32'd0);
    check("fin_start_done",     32'(done),         32'd1);
    check("fin_start_key",      32'(key_out),      32'h000249);
    check("fin_start_ph_start", 32'(bus.ph_start), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_done_hold", 32'(done), 32'd1);
    check("idle_busy",      32'(busy), 32'd0);
    start = 1'b1; key_in = 24'h0ABCDE;
    @(negedge clk);
    start = 1'b0;
    check("restart_done", 32'(done),    32'd0);
    check("restart_busy", 32'(busy),    32'd1);
    check("restart_key",  32'(key_out), 32'h0ABCDE);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

`ifdef RC4_KEY_SEARCH_EN
    // Search accepted at key 3
    start = 1'b1; key_in = 24'd0;
    @(negedge clk);
    start = 1'b0;
    gaps = 0;
    for (int k = 0; k < 4; k++) begin
      check("srch_ok_key", 32'(key_out), 32'(k));
      run_pass(k == 3);
    end
    check("srch_ok_found", 32'(key_found), 32'd1);
    check("srch_ok_fail",  32'(key_fail),  32'd0);
    check("srch_ok_key3",  32'(key_out),   32'd3);
    check("srch_ok_done",  32'(done),      32'd1);
    check("srch_ok_gaps",  32'(gaps),      32'd0);
    @(negedge clk);

    // Search exhausts the top four keys without wrapping
    start = 1'b1; key_in = 24'hFFFFFC;
    @(negedge clk);
    start = 1'b0;
    check("srch_fail_found_clr", 32'(key_found), 32'd0);
    gaps = 0;
    for (int k = 0; k < 4; k++) begin
      check("srch_fail_key", 32'(key_out), 32'(24'hFFFFFC + k));
      run_pass(1'b0);
    end
    check("srch_fail_fail",  32'(key_fail),  32'd1);
    check("srch_fail_found", 32'(key_found), 32'd0);
    check("srch_fail_key1s", 32'(key_out),   32'hFFFFFF);
    check("srch_fail_busy",  32'(busy),      32'd0);
    check("srch_fail_gaps",  32'(gaps),      32'd0);
    @(negedge clk);
    check("srch_fail_nowrap", 32'(key_out), 32'hFFFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
